// File: rtl/axis_rr_arbiter_if.sv
// AXI4-Stream bundle (tvalid/tready/tdata/tlast) shared by the requester and the
// master sides of the round-robin packet arbiter.
interface axis_rr_arbiter_if #(
    parameter int unsigned TDATA_WIDTH = 32
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Two-requester AXI4-Stream packet arbiter: a packet is locked to one requester from
// first beat to tlast handshake, ties are broken round-robin, completed packets counted.
module axis_rr_arbiter #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_PKT_CNT_WIDTH    = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    axis_rr_arbiter_if.slave           s00_axis,
    axis_rr_arbiter_if.slave           s01_axis,
    axis_rr_arbiter_if.master          m00_axis,
    output logic                       grant_valid,
    output logic                       grant_id,
    output logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt0,
    output logic [C_PKT_CNT_WIDTH-1:0] pkt_cnt1
);

    localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
    localparam int unsigned CW = C_PKT_CNT_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            grant_id_q, grant_id_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   pkt_cnt0_q, pkt_cnt0_d;
    logic [CW-1:0]   pkt_cnt1_q, pkt_cnt1_d;

    logic            busy;
    logic            sel_tvalid;
    logic            sel_tlast;
    logic [DW-1:0]   sel_tdata;
    logic            pkt_done;

    assign busy = (state_q == ST_BUSY);

    // Granted-port select; only visible on m00 while a packet is locked.
    always_comb begin
        sel_tvalid = s00_axis.tvalid;
        sel_tdata  = s00_axis.tdata;
        sel_tlast  = s00_axis.tlast;
        if (grant_id_q) begin
            sel_tvalid = s01_axis.tvalid;
            sel_tdata  = s01_axis.tdata;
            sel_tlast  = s01_axis.tlast;
        end
    end

    assign m00_axis.tvalid = busy & sel_tvalid;
    assign m00_axis.tdata  = busy ? sel_tdata : '0;
    assign m00_axis.tlast  = busy & sel_tlast;

    assign s00_axis.tready = busy & ~grant_id_q & m00_axis.tready;
    assign s01_axis.tready = busy &  grant_id_q & m00_axis.tready;

    assign pkt_done = busy & sel_tvalid & sel_tlast & m00_axis.tready;

    assign grant_valid = busy;
    assign grant_id    = grant_id_q;
    assign pkt_cnt0    = pkt_cnt0_q;
    assign pkt_cnt1    = pkt_cnt1_q;

    // Next-state: arbitrate in IDLE, hold the grant until the tlast handshake.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s00_axis.tvalid && s01_axis.tvalid) begin
                    state_d    = ST_BUSY;
                    grant_id_d = ~last_grant_q;
                end else if (s00_axis.tvalid) begin
                    state_d    = ST_BUSY;
                    grant_id_d = 1'b0;
                end else if (s01_axis.tvalid) begin
                    state_d    = ST_BUSY;
                    grant_id_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (pkt_done) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_id_q;
                    if (grant_id_q) begin
                        pkt_cnt1_d = pkt_cnt1_q + CW'(1);
                    end else begin
                        pkt_cnt0_d = pkt_cnt0_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed and randomized bench for axis_rr_arbiter against a packet-level model
// (owner / preferred port / per-port packet counts).
module tb_axis_rr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    axis_rr_arbiter_if #(.TDATA_WIDTH(DW)) s00_axis ();
    axis_rr_arbiter_if #(.TDATA_WIDTH(DW)) s01_axis ();
    axis_rr_arbiter_if #(.TDATA_WIDTH(DW)) m00_axis ();

    logic          grant_valid;
    logic          grant_id;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;

    axis_rr_arbiter #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_PKT_CNT_WIDTH   (CW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s00_axis   (s00_axis),
        .s01_axis   (s01_axis),
        .m00_axis   (m00_axis),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who owns m00 (-1 none), who wins the next tie, packet counts.
    int owner  = -1;
    int prefer = 0;
    int cnt[2] = '{0, 0};

    // Sources: queued beats {tlast, tdata}; a presented beat is held until accepted.
    logic [DW:0]   sq0[$];
    logic [DW:0]   sq1[$];
    logic [DW-1:0] ex0[$];
    logic [DW-1:0] ex1[$];
    logic [DW-1:0] outq[$];
    logic [DW-1:0] want[$];
    bit            pres[2];
    logic          v[2];
    logic          l[2];
    logic [DW-1:0] d[2];
    logic          mrdy;
    int            mode = 0;
    int            gap  = 0;
    int            tog  = 0;
    int            seqn = 0;
    int            exp031[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            if (p == 0) begin
                sq0.push_back({(i == len - 1), base + DW'(i)});
                ex0.push_back(base + DW'(i));
            end else begin
                sq1.push_back({(i == len - 1), base + DW'(i)});
                ex1.push_back(base + DW'(i));
            end
        end
    endtask

    task automatic clear_logs();
        outq.delete();
        ex0.delete();
        ex1.delete();
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic cycle();
        logic [DW:0]   b;
        int            sz;
        logic          ev, el, er0, er1, omv;
        logic [DW-1:0] ed, omd;
        for (int p = 0; p < 2; p++) begin
            sz = (p == 0) ? sq0.size() : sq1.size();
            if (!pres[p] && sz > 0 && ($urandom_range(99) >= gap)) pres[p] = 1'b1;
            if (pres[p]) begin
                b    = (p == 0) ? sq0[0] : sq1[0];
                v[p] = 1'b1;
                d[p] = b[DW-1:0];
                l[p] = b[DW];
            end else begin
                v[p] = 1'b0;
                d[p] = $urandom;
                l[p] = 1'($urandom_range(1));
            end
        end
        case (mode)
            1:       mrdy = (tog % 2 == 0);
            2:       mrdy = 1'($urandom_range(1));
            default: mrdy = 1'b1;
        endcase
        tog++;
        s00_axis.tvalid = v[0];  s00_axis.tdata = d[0];  s00_axis.tlast = l[0];
        s01_axis.tvalid = v[1];  s01_axis.tdata = d[1];  s01_axis.tlast = l[1];
        m00_axis.tready = mrdy;
        #1;
        ev  = (owner >= 0) ? v[owner] : 1'b0;
        ed  = (owner >= 0) ? d[owner] : '0;
        el  = (owner >= 0) ? l[owner] : 1'b0;
        er0 = (owner == 0) && mrdy;
        er1 = (owner == 1) && mrdy;
        chk("m_tvalid", m00_axis.tvalid, ev);
        chk("m_tdata", m00_axis.tdata, ed);
        chk("m_tlast", m00_axis.tlast, el);
        chk("s0_tready", s00_axis.tready, er0);
        chk("s1_tready", s01_axis.tready, er1);
        chk("grant_valid", grant_valid, owner >= 0);
        if (owner >= 0) chk("grant_id", grant_id, owner);
        chk("pkt_cnt0", pkt_cnt0, cnt[0]);
        chk("pkt_cnt1", pkt_cnt1, cnt[1]);
        omv = m00_axis.tvalid;
        omd = m00_axis.tdata;
        @(posedge aclk);
        if (pres[0] && er0) begin void'(sq0.pop_front()); pres[0] = 1'b0; end
        if (pres[1] && er1) begin void'(sq1.pop_front()); pres[1] = 1'b0; end
        if (omv === 1'b1 && mrdy) outq.push_back(omd);
        if (owner < 0) begin
            if (v[0] && v[1]) owner = prefer;
            else if (v[0])    owner = 0;
            else if (v[1])    owner = 1;
        end else if (v[owner] && mrdy && l[owner]) begin
            cnt[owner] = (cnt[owner] + 1) % (1 << CW);
            prefer     = 1 - owner;
            owner      = -1;
        end
        @(negedge aclk);
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int k = 0;
        while ((sq0.size() != 0 || sq1.size() != 0 || owner >= 0) && k < max) begin
            cycle();
            k++;
        end
        chk({tag, "_drained"}, (sq0.size() != 0 || sq1.size() != 0 || owner >= 0), 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        #2 aresetn = 1'b0;
        #1;
        chk("rst_m_tvalid", m00_axis.tvalid, 1'b0);
        chk("rst_m_tdata", m00_axis.tdata, 0);
        chk("rst_m_tlast", m00_axis.tlast, 1'b0);
        chk("rst_s0_tready", s00_axis.tready, 1'b0);
        chk("rst_s1_tready", s01_axis.tready, 1'b0);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_pkt_cnt0", pkt_cnt0, 0);
        chk("rst_pkt_cnt1", pkt_cnt1, 0);
        owner  = -1;
        prefer = 0;
        cnt    = '{0, 0};
        pres   = '{1'b0, 1'b0};
        sq0.delete();
        sq1.delete();
        s00_axis.tvalid = 1'b0;
        s01_axis.tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        tog = 0;
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_nbeats"}, outq.size(), want.size());
        for (int i = 0; i < want.size() && i < outq.size(); i++)
            chk({tag, "_beat"}, outq[i], want[i]);
    endtask

    task automatic cmp_split(input string tag);
        logic [DW-1:0] o0[$];
        logic [DW-1:0] o1[$];
        foreach (outq[i]) begin
            if (outq[i][DW-1]) o1.push_back(outq[i]);
            else               o0.push_back(outq[i]);
        end
        chk({tag, "_n0"}, o0.size(), ex0.size());
        chk({tag, "_n1"}, o1.size(), ex1.size());
        for (int i = 0; i < o0.size() && i < ex0.size(); i++) chk({tag, "_p0"}, o0[i], ex0[i]);
        for (int i = 0; i < o1.size() && i < ex1.size(); i++) chk({tag, "_p1"}, o1[i], ex1[i]);
    endtask

    initial begin
        int k;
        int pp;
        int len;
        s00_axis.tvalid = 1'b0; s00_axis.tdata = '0; s00_axis.tlast = 1'b0;
        s01_axis.tvalid = 1'b0; s01_axis.tdata = '0; s01_axis.tlast = 1'b0;
        m00_axis.tready = 1'b0;
        pres = '{1'b0, 1'b0};

        // Power-on reset
        @(negedge aclk);
        do_reset();
        repeat (3) cycle();

        // Single 3-beat packet on port 0
        clear_logs();
        add_pkt(0, 3, 32'h0);
        run_until_idle("r026", 20);
        want = '{32'h0, 32'h1, 32'h2};
        cmp_out("r026");
        chk("r026_cnt0", pkt_cnt0, 1);

        // Simultaneous requests from reset: port 0 first, then port 1
        do_reset();
        clear_logs();
        add_pkt(0, 2, 32'hA0);
        add_pkt(1, 2, 32'hB0);
        run_until_idle("r027", 20);
        want = '{32'hA0, 32'hA1, 32'hB0, 32'hB1};
        cmp_out("r027");
        chk("r027_cnt0", pkt_cnt0, 1);
        chk("r027_cnt1", pkt_cnt1, 1);

        // Port 1 arrives while port 0 owns the stream
        clear_logs();
        add_pkt(0, 3, 32'h10);
        cycle();
        add_pkt(1, 2, 32'h20);
        run_until_idle("r028", 20);
        want = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21};
        cmp_out("r028");

        // Back-pressure toggling 1,0,1,0 on a 4-beat packet
        clear_logs();
        add_pkt(0, 4, 32'h30);
        cycle();
        mode = 1;
        tog  = 0;
        run_until_idle("r029", 30);
        mode = 0;
        want = '{32'h30, 32'h31, 32'h32, 32'h33};
        cmp_out("r029");

        // Randomized traffic: gaps, random back-pressure, both ports contending
        clear_logs();
        mode = 2;
        gap  = 30;
        for (int batch = 0; batch < 3; batch++) begin
            for (int n = 0; n < 20; n++) begin
                pp  = $urandom_range(1);
                len = $urandom_range(4, 1);
                add_pkt(pp, len, {pp[0], 31'(seqn)});
                seqn += len;
            end
            run_until_idle("rand", 3000);
            repeat (2) cycle();
        end
        cmp_split("rand");
        mode = 0;
        gap  = 0;

        // Reset after the first beat of a 4-beat packet; port 0 must win the next tie
        clear_logs();
        add_pkt(0, 1, 32'h3F);
        run_until_idle("r030a", 10);
        clear_logs();
        add_pkt(0, 4, 32'h40);
        k = 0;
        while (outq.size() < 1 && k < 20) begin
            cycle();
            k++;
        end
        chk("r030_first_beat", outq.size(), 1);
        do_reset();
        clear_logs();
        add_pkt(1, 2, 32'h70);
        add_pkt(0, 2, 32'h60);
        run_until_idle("r030b", 20);
        want = '{32'h60, 32'h61, 32'h70, 32'h71};
        cmp_out("r030");

        // Counter wrap with a 2-bit counter: 1,2,3,0,1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            add_pkt(0, 1, DW'(i));
            run_until_idle("r031", 10);
            chk("r031_cnt0", pkt_cnt0, exp031[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32, data width of every stream port.
REQ-002 SHALL have parameter C_PKT_CNT_WIDTH, default 16, width of each per-port packet counter.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 s00_axis_tvalid / s00_axis_tready / s00_axis_tdata / s00_axis_tlast  in / out / in [C_AXIS_TDATA_WIDTH] / in  requester 0 slave stream.
REQ-006 s01_axis_tvalid / s01_axis_tready / s01_axis_tdata / s01_axis_tlast  in / out / in [C_AXIS_TDATA_WIDTH] / in  requester 1 slave stream.
REQ-007 m00_axis_tvalid / m00_axis_tready / m00_axis_tdata / m00_axis_tlast  out / in / out [C_AXIS_TDATA_WIDTH] / out  shared master stream.
REQ-008 grant_valid  output  1  high while a packet is locked to a requester.
REQ-009 grant_id  output  1  index of the granted requester; meaningful only when grant_valid=1.
REQ-010 pkt_cnt0 / pkt_cnt1  output  C_PKT_CNT_WIDTH each  completed-packet count per requester.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY; the state, grant_id, last_grant and counters are registers.
REQ-012 IDLE: m00_axis_tvalid=0, both s*_axis_tready=0, grant_valid=0; m00_axis_tdata/tlast SHALL be driven 0.
REQ-013 IDLE, rising edge, only one s*_axis_tvalid=1: go to BUSY with grant_id = that port.
REQ-014 IDLE, both tvalid=1: grant_id = ~last_grant (round-robin); last_grant reset value 1, so port 0 wins first.
REQ-015 IDLE, no tvalid: remain IDLE, no register change except state hold.
REQ-016 BUSY: m00_axis_tvalid/tdata/tlast SHALL combinationally equal the granted port's tvalid/tdata/tlast; granted s*_axis_tready = m00_axis_tready; non-granted tready=0.
REQ-017 Arbitration latency: first beat appears on m00 the cycle after the edge at which IDLE saw tvalid (one-cycle bubble per packet).
REQ-018 Grant SHALL be held for the whole packet regardless of the other port's tvalid; no beat interleaving.
REQ-019 BUSY, edge with m00_axis_tvalid & m00_axis_tready & m00_axis_tlast: go to IDLE, last_grant <= grant_id, pkt_cnt[grant_id] += 1.
REQ-020 Packet counters SHALL wrap modulo 2^C_PKT_CNT_WIDTH (all-ones + 1 -> 0), no saturation.
REQ-021 Granted tvalid dropping mid-packet SHALL NOT release the grant; FSM waits in BUSY.
REQ-022 Single-beat packet (tlast on first beat) SHALL complete in one BUSY cycle when m00_axis_tready=1.
REQ-023 m00_axis_tready=0 in BUSY: all outputs hold pass-through values; no state change.

Reset
REQ-024 aresetn=0 SHALL immediately force IDLE, grant_valid=0, grant_id=0, last_grant=1, pkt_cnt0=pkt_cnt1=0, all treadys and m00_axis_tvalid=0.
REQ-025 Reset mid-packet SHALL abandon the packet without incrementing any counter; after release arbitration restarts from IDLE with port 0 priority.

Verification
REQ-026 Port 0 sends 3-beat packet (data 0,1,2; tlast on 2), m00_axis_tready=1 -> m00 beats 0,1,2 on consecutive cycles starting 1 cycle after tvalid, pkt_cnt0=1.
REQ-027 Both ports valid at same edge from reset, each 2-beat packets (0xA0,0xA1 / 0xB0,0xB1) -> m00 order A0,A1,[bubble],B0,B1; pkt_cnt0=1, pkt_cnt1=1.
REQ-028 Port 1 valid during a port 0 packet -> s01_axis_tready stays 0 until port 0 tlast handshake; no interleaved beat on m00.
REQ-029 m00_axis_tready toggled 1,0,1,0 during a 4-beat packet -> every beat delivered exactly once, tdata stable while stalled.
REQ-030 aresetn asserted after beat 1 of a 4-beat packet -> outputs zero asynchronously, counters 0, next packet granted to port 0 when both valid.
REQ-031 C_PKT_CNT_WIDTH=2, port 0 sends 5 single-beat packets -> pkt_cnt0 sequence 1,2,3,0,1.
